// File: rtl/mult_16_seq.sv
// ============================================================================
// mult_16_seq : sequential unsigned 16x16->32 shift-and-add multiplier
//               built around a single adder_16 instance.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module adder_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {16'h0000, c_in};

endmodule

module mult_16_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] mcand, mcand_nxt;
  logic [32:0] acc, acc_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] product_nxt;

  logic [15:0] add_a;
  logic [15:0] add_sum;
  logic        add_cout;

  assign add_a = acc[0] ? mcand : 16'h0000;

  adder_16 u_adder (
    .a     (add_a),
    .b     (acc[31:16]),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mcand   <= 16'h0000;
      acc     <= 33'h0;
      cnt     <= 4'h0;
      product <= 32'h0;
    end else begin
      state   <= state_nxt;
      mcand   <= mcand_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      product <= product_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mcand_nxt   = mcand;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    product_nxt = product;

    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start) begin
          mcand_nxt = a;
          acc_nxt   = {17'h0, b};
          cnt_nxt   = 4'h0;
          state_nxt = CALC;
        end
      end

      CALC: begin
        // Add then shift right; bit 32 is cleared by every shift.
        acc_nxt = {acc[32] & 1'b0, add_cout, add_sum, acc[15:1]};
        cnt_nxt = cnt + 4'h1;
        if (cnt == 4'hF) begin
          product_nxt = acc_nxt[31:0];
          state_nxt   = DONE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_16_seq.sv
// Self-checking bench for mult_16_seq: vector table plus a product scoreboard.
`default_nettype none

module tb_mult_16_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int errors = 0;
  int checks = 0;
  int done_count = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[10];

  mult_16_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected product.
  always @(posedge clk) begin
    #1;
    if (done) begin
      done_count++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        chk("product", product, sb.pop_front());
      end
    end
  end

  // Assumes DUT is idle. Start one op, check busy during, latency 17 and hold.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic [31:0] vp);
    int cyc;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    sb.push_back(vp);
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    cyc = 1;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, 32'd17);
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("product_hold", product, vp);
  endtask

  initial begin
    int cyc;
    int dc;
    vecs[0] = '{16'd4,    16'd3,    32'h0000000C};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{16'd1025, 16'd255,  32'h0003FCFF};
    vecs[3] = '{16'h1234, 16'h0000, 32'h00000000};
    vecs[4] = '{16'h0000, 16'hFFFF, 32'h00000000};
    vecs[5] = '{16'h0001, 16'h0001, 32'h00000001};
    vecs[6] = '{16'h8000, 16'h8000, 32'h40000000};
    vecs[7] = '{16'h00FF, 16'h0101, 32'h0000FFFF};
    vecs[8] = '{16'h1000, 16'h0010, 32'h00010000};
    vecs[9] = '{16'hFFFF, 16'h0002, 32'h0001FFFE};

    reset = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_product", product, 32'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 10; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p);

    // Start pulse while busy must be ignored.
    @(negedge clk);
    a = 16'd8; b = 16'd7; start = 1'b1; sb.push_back(32'h38);
    dc = done_count;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); a = 16'd2; b = 16'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("ignored_start_one_done", done_count - dc, 32'd1);
    chk("ignored_start_idle", {31'd0, busy}, 32'd0);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 16'd2; b = 16'd3; start = 1'b1; sb.push_back(32'd6);
    @(posedge clk); #1;
    cyc = 1;
    while (!done && cyc < 40) begin
      chk("b2b_busy1", {31'd0, busy}, 32'd1);
      @(posedge clk); #1; cyc++;
    end
    chk("b2b_latency1", cyc, 32'd17);
    chk("b2b_busy_done1", {31'd0, busy}, 32'd0);
    a = 16'd5; b = 16'd5; sb.push_back(32'h19);
    @(posedge clk); #1;
    cyc = 1;
    while (!done && cyc < 40) begin
      chk("b2b_busy2", {31'd0, busy}, 32'd1);
      @(posedge clk); #1; cyc++;
    end
    chk("b2b_latency2", cyc, 32'd17);
    chk("b2b_busy_done2", {31'd0, busy}, 32'd0);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_idle", {31'd0, busy}, 32'd0);
    chk("b2b_hold", product, 32'h19);

    // Reset mid-operation aborts with no done and clears product.
    @(negedge clk);
    a = 16'hFFFF; b = 16'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("midop_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_product", product, 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    chk("reset_beats_start", {31'd0, busy}, 32'd0);
    start = 1'b0; reset = 1'b0;
    dc = done_count;
    repeat (25) @(posedge clk);
    #1;
    chk("abort_no_done", done_count - dc, 32'd0);
    run_op(16'hFFFF, 16'd2, 32'h0001FFFE);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mult_16_seq.md
Name: mult_16_seq

Overview:
- Sequential unsigned 16x16 -> 32-bit shift-and-add multiplier.
- Sits directly above adder_16 and uses one instance of it as its only adder. Each iteration it feeds adder_16 with a/b/c_in and consumes the sum and c_out it produces.
- Used by the lab datapath wherever a product is needed without a combinational array multiplier.

Parameters:
- none. Width is fixed at 16 by adder_16.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled on the rising edge of clk
- a  input  16  multiplicand; captured on the accepted start edge
- b  input  16  multiplier; captured on the accepted start edge
- busy  output  1  high while iterating (state CALC)
- done  output  1  one-cycle pulse: product is valid
- product  output  32  last completed result; held until the next result completes

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - reset is synchronous and active-high. On any clk edge with reset=1: state=IDLE, busy=0, done=0, product=0, internal registers=0.
  - reset has priority over everything, including mid-operation. An aborted operation produces no done and no product update.
- Internal registers:
  - mcand[15:0] holds the captured a.
  - acc[32:0] holds the partial product: acc[32]=carry, acc[31:16]=upper, acc[15:0]=low/multiplier.
  - cnt[3:0] counts iterations.
- adder_16 hookup:
  - adder_16.a = acc[0] ? mcand : 16'h0000
  - adder_16.b = acc[31:16]
  - adder_16.c_in = 0
- States: IDLE, CALC, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1: mcand<=a, acc<={17'b0, b}, cnt<=0, go to CALC.
- CALC:
  - busy=1, done=0.
  - Each edge: acc <= {1'b0, c_out, sum, acc[15:1]}. This is add-then-shift-right; c_out lands in bit 31.
  - cnt<=cnt+1.
  - On the edge where cnt==15 (the 16th iteration): also load product<=new acc[31:0] and go to DONE.
  - start is ignored in CALC. a and b may change freely after capture.
- DONE:
  - busy=0, done=1 for exactly this one cycle.
  - If start=1: accept a new operation exactly as in IDLE (back-to-back) and go to CALC. Otherwise go to IDLE.
- Latency:
  - Start accepted at edge N -> done high in the cycle after edge N+16 (17 edges).
  - Throughput is one result per 17 cycles with back-to-back starts.
- Product rules:
  - product changes only on the edge entering DONE, or on reset.
  - product never shows intermediate values.
- Width and overflow:
  - The result is exact; 0xFFFF*0xFFFF fits in 32 bits.
  - acc[32] is always 0 after the shift and exists only for uniformity.
- Simultaneous events:
  - reset=1 together with start=1: reset wins and start is dropped.
  - start held high continuously: a new operation starts at each IDLE/DONE visit.
- Operand edge cases:
  - b=0 or a=0 yields product=0 after the full 16 iterations. There is no early termination.

Test Plan:
- Basic: reset 2 cycles, then a=4, b=3, start=1 for 1 cycle -> busy=1 for 16 cycles; done pulses on the 17th edge with product=0x0000000C; product holds afterwards.
- Carry path: a=0xFFFF, b=0xFFFF -> product=0xFFFE0001 (exercises adder_16 c_out every iteration). Also a=1025, b=255 -> product=0x0003FCFF.
- Zero operands: a=0x1234, b=0 -> product=0x00000000 after 17 cycles. Repeat with a=0, b=0xFFFF -> product=0.
- Start ignored while busy: start a=8, b=7; pulse start with a=2, b=2 at cycle 5 -> product=0x00000038, exactly one done pulse, no restart.
- Back-to-back: hold start=1 with a=2, b=3 then change to a=5, b=5 in the DONE cycle -> first done gives product=6, a second done 17 cycles later gives product=0x19, and busy=0 only in the DONE cycles.
- Reset mid-op: start a=0xFFFF, b=2, assert reset at cycle 8 -> next cycle busy=0, done=0, product=0, and no done pulse follows. A new start then completes normally with product=0x0001FFFE.
